// File: rtl/lbm_moment_if.sv
// Handshake and data bundle between the D2Q9 moment engine, its fin memory and the controller.
// The engine is the slave side: it reads fin memory and answers the controller's load strobes.
interface lbm_moment_if #(
    parameter int GRID_DIM   = 16*16,
    parameter int DATA_WIDTH = 32
);
    localparam int AW = $clog2(GRID_DIM*9);
    localparam int CW = $clog2(GRID_DIM);

    logic                  start;
    logic [DATA_WIDTH-1:0] fin_rdata;
    logic                  LD_EN_P;
    logic                  LD_EN_PUX;
    logic                  LD_EN_PUY;
    logic                  fin_rd;
    logic [AW-1:0]         fin_addr;
    logic [CW-1:0]         count_init;
    logic                  cell_done;
    logic [DATA_WIDTH-1:0] p_out;
    logic [DATA_WIDTH-1:0] pux_out;
    logic [DATA_WIDTH-1:0] puy_out;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output start, fin_rdata, LD_EN_P, LD_EN_PUX, LD_EN_PUY,
        input  fin_rd, fin_addr, count_init, cell_done, p_out, pux_out, puy_out, busy, frame_done
    );

    modport slave (
        input  start, fin_rdata, LD_EN_P, LD_EN_PUX, LD_EN_PUY,
        output fin_rd, fin_addr, count_init, cell_done, p_out, pux_out, puy_out, busy, frame_done
    );
endinterface

// File: rtl/lbm_moment_engine.sv
// D2Q9 moment engine: streams nine fin samples per cell, accumulates density and momenta,
// and holds the saturated results until the controller has strobed all three consumed.
module lbm_moment_engine #(
    parameter int GRID_DIM   = 16*16,
    parameter int DATA_WIDTH = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    lbm_moment_if.slave  bus
);
    localparam int AW    = $clog2(GRID_DIM*9);
    localparam int CW    = $clog2(GRID_DIM);
    localparam int ACC_W = DATA_WIDTH + 4;
    localparam logic signed [ACC_W-1:0] MAXV = {5'b00000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {5'b11111, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] LAST_CELL = CW'(GRID_DIM-1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WAIT_LD, FINISH} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               dir_q, dir_d;
    logic [3:0]               rd_dir_q, rd_dir_d;
    logic                     rd_vld_q, rd_vld_d;
    logic [CW-1:0]            cell_q, cell_d;
    logic [2:0]               seen_q, seen_d;
    logic signed [ACC_W-1:0]  acc_p_q, acc_p_d, acc_x_q, acc_x_d, acc_y_q, acc_y_d;
    logic [DATA_WIDTH-1:0]    p_q, p_d, pux_q, pux_d, puy_q, puy_d;

    logic signed [ACC_W-1:0]  samp, sum_p, sum_x, sum_y;
    logic [2:0]               seen_now;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [ACC_W-1:0] a);
        if (a > MAXV)      return MAXV[DATA_WIDTH-1:0];
        else if (a < MINV) return MINV[DATA_WIDTH-1:0];
        else               return a[DATA_WIDTH-1:0];
    endfunction

    // Sample returning this cycle belongs to the direction issued last cycle.
    always_comb begin
        samp  = {{4{bus.fin_rdata[DATA_WIDTH-1]}}, bus.fin_rdata};
        sum_p = acc_p_q + samp;
        sum_x = acc_x_q;
        sum_y = acc_y_q;
        case (rd_dir_q)
            4'd1, 4'd5, 4'd8: sum_x = acc_x_q + samp;
            4'd3, 4'd6, 4'd7: sum_x = acc_x_q - samp;
            default:          sum_x = acc_x_q;
        endcase
        case (rd_dir_q)
            4'd2, 4'd5, 4'd6: sum_y = acc_y_q + samp;
            4'd4, 4'd7, 4'd8: sum_y = acc_y_q - samp;
            default:          sum_y = acc_y_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        rd_dir_d = dir_q;
        rd_vld_d = 1'b0;
        cell_d   = cell_q;
        seen_d   = seen_q;
        acc_p_d  = acc_p_q;
        acc_x_d  = acc_x_q;
        acc_y_d  = acc_y_q;
        p_d      = p_q;
        pux_d    = pux_q;
        puy_d    = puy_q;
        seen_now = seen_q | {bus.LD_EN_P, bus.LD_EN_PUX, bus.LD_EN_PUY};

        if (rd_vld_q) begin
            acc_p_d = sum_p;
            acc_x_d = sum_x;
            acc_y_d = sum_y;
        end

        case (state_q)
            IDLE: if (bus.start) begin
                state_d = READ;
                cell_d  = '0;
                dir_d   = '0;
                seen_d  = '0;
                acc_p_d = '0;
                acc_x_d = '0;
                acc_y_d = '0;
            end
            READ: begin
                rd_vld_d = 1'b1;
                if (dir_q == 4'd8) begin
                    dir_d   = '0;
                    state_d = DRAIN;
                end else begin
                    dir_d = dir_q + 4'd1;
                end
            end
            DRAIN: begin
                p_d     = sat(sum_p);
                pux_d   = sat(sum_x);
                puy_d   = sat(sum_y);
                state_d = WAIT_LD;
            end
            WAIT_LD: begin
                seen_d = seen_now;
                if (&seen_now) begin
                    seen_d  = '0;
                    acc_p_d = '0;
                    acc_x_d = '0;
                    acc_y_d = '0;
                    if (cell_q == LAST_CELL) begin
                        state_d = FINISH;
                    end else begin
                        cell_d  = cell_q + CW'(1);
                        state_d = READ;
                    end
                end
            end
            FINISH: begin
                cell_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            dir_q    <= '0;
            rd_dir_q <= '0;
            rd_vld_q <= 1'b0;
            cell_q   <= '0;
            seen_q   <= '0;
            acc_p_q  <= '0;
            acc_x_q  <= '0;
            acc_y_q  <= '0;
            p_q      <= '0;
            pux_q    <= '0;
            puy_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            rd_dir_q <= rd_dir_d;
            rd_vld_q <= rd_vld_d;
            cell_q   <= cell_d;
            seen_q   <= seen_d;
            acc_p_q  <= acc_p_d;
            acc_x_q  <= acc_x_d;
            acc_y_q  <= acc_y_d;
            p_q      <= p_d;
            pux_q    <= pux_d;
            puy_q    <= puy_d;
        end
    end

    assign bus.fin_rd     = (state_q == READ);
    assign bus.fin_addr   = (state_q == READ) ? (AW'(cell_q) * AW'(9) + AW'(dir_q)) : '0;
    assign bus.count_init = cell_q;
    assign bus.cell_done  = (state_q == WAIT_LD);
    assign bus.busy       = (state_q == READ) || (state_q == DRAIN) || (state_q == WAIT_LD);
    assign bus.frame_done = (state_q == FINISH);
    assign bus.p_out      = p_q;
    assign bus.pux_out    = pux_q;
    assign bus.puy_out    = puy_q;
endmodule
